// File: rtl/count_source_sel_pkg.sv
// Shared constants for the counter count-source selector.
// Mode and FSM encodings plus a selection validity helper.
package cnt_src_pkg;

  localparam logic [2:0] MODE_STOP = 3'd0;
  localparam logic [2:0] MODE_TICK = 3'd1;
  localparam logic [2:0] MODE_RISE = 3'd2;
  localparam logic [2:0] MODE_FALL = 3'd3;
  localparam logic [2:0] MODE_ANY  = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  function automatic logic sel_bad(
    input int         ch,
    input logic [2:0] mode,
    input int         n_ch
  );
    return (ch >= n_ch) || (mode > MODE_ANY);
  endfunction

endpackage

// File: rtl/count_source_sel_if.sv
// Board-side bundle of the count-source selector.
// master drives the selection and inputs, slave returns pulses/status.
interface count_source_sel_if #(
  parameter int N_CH    = 4,
  parameter int PRESC_W = 16
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic               iEnable;
  logic [N_CH-1:0]    ivIn;
  logic [CH_W-1:0]    ivChan;
  logic [2:0]         ivMode;
  logic [PRESC_W-1:0] ivPrescale;
  logic               oPulse;
  logic               oChanged;
  logic               oActive;
  logic               oSelErr;

  modport master (
    output iEnable, ivIn, ivChan,
    output ivMode, ivPrescale,
    input  oPulse, oChanged,
    input  oActive, oSelErr
  );

  modport slave (
    input  iEnable, ivIn, ivChan,
    input  ivMode, ivPrescale,
    output oPulse, oChanged,
    output oActive, oSelErr
  );

endinterface

// File: rtl/count_source_sel_edge_sync_det.sv
// Per-channel synchroniser with previous-value flop.
// Produces rise/fall/any-edge strobes from the synchronised level.
module edge_sync_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iClk,
  input  logic iReset,
  input  logic iIn,
  output logic oRise,
  output logic oFall,
  output logic oAny
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], iIn};
      r_prev <= w_s;
    end
  end

  assign oRise = w_s & ~r_prev;
  assign oFall = ~w_s & r_prev;
  assign oAny  = w_s ^ r_prev;

endmodule

// File: rtl/count_source_sel.sv
// Count-source selector: picks a synchronised channel edge or a
// prescaled tick and emits a registered one-cycle count pulse.
module count_source_sel
  import cnt_src_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PRESC_W     = 16
) (
  input  logic              iClk,
  input  logic              iReset,
  count_source_sel_if.slave bus
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BC_W = $clog2(SYNC_STAGES + 2);
  localparam logic [BC_W-1:0] BLANK_LEN =
    BC_W'(SYNC_STAGES + 1);

  logic [N_CH-1:0]    w_rise;
  logic [N_CH-1:0]    w_fall;
  logic [N_CH-1:0]    w_any;

  logic [CH_W-1:0]    r_ch;
  logic [2:0]         r_mode;
  logic [1:0]         r_state;
  logic [BC_W-1:0]    r_bcnt;
  logic [PRESC_W-1:0] r_presc;
  logic               r_pulse;
  logic               r_chg;
  logic               r_selerr;

  logic w_change;
  logic w_new_err;
  logic w_held_ok;
  logic w_ch_rise;
  logic w_ch_fall;
  logic w_ch_any;
  logic w_tick;
  logic w_event;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_sync_det #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_det (
      .iClk  (iClk),
      .iReset(iReset),
      .iIn   (bus.ivIn[g]),
      .oRise (w_rise[g]),
      .oFall (w_fall[g]),
      .oAny  (w_any[g])
    );
  end

  assign w_change = (bus.ivChan != r_ch) ||
                    (bus.ivMode != r_mode);

  assign w_new_err = sel_bad(int'(bus.ivChan),
                             bus.ivMode, N_CH);

  assign w_held_ok = !sel_bad(int'(r_ch), r_mode, N_CH) &&
                     (r_mode != MODE_STOP);

  assign w_tick = (r_presc == bus.ivPrescale);

  // Compare-based mux: an out-of-range channel selects nothing.
  always_comb begin
    w_ch_rise = 1'b0;
    w_ch_fall = 1'b0;
    w_ch_any  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(r_ch) == i) begin
        w_ch_rise = w_rise[i];
        w_ch_fall = w_fall[i];
        w_ch_any  = w_any[i];
      end
    end
  end

  always_comb begin
    w_event = 1'b0;
    unique case (r_mode)
      MODE_TICK: w_event = w_tick;
      MODE_RISE: w_event = w_ch_rise;
      MODE_FALL: w_event = w_ch_fall;
      MODE_ANY:  w_event = w_ch_any;
      default:   w_event = 1'b0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_ch     <= '0;
      r_mode   <= MODE_STOP;
      r_state  <= ST_IDLE;
      r_bcnt   <= '0;
      r_presc  <= '0;
      r_pulse  <= 1'b0;
      r_chg    <= 1'b0;
      r_selerr <= 1'b0;
    end else begin
      r_chg   <= w_change;
      r_pulse <= 1'b0;
      if (w_change) begin
        // A change always wins over a same-cycle event.
        r_ch     <= bus.ivChan;
        r_mode   <= bus.ivMode;
        r_selerr <= w_new_err;
        r_bcnt   <= BLANK_LEN;
        r_state  <= ST_BLANK;
      end else begin
        unique case (r_state)
          ST_BLANK: begin
            r_bcnt <= r_bcnt - 1'b1;
            if (r_bcnt == BC_W'(1)) begin
              r_presc <= '0;
              r_state <= w_held_ok ? ST_RUN : ST_IDLE;
            end
          end
          ST_RUN: begin
            r_pulse <= bus.iEnable & w_event;
            if (bus.iEnable && r_mode == MODE_TICK)
              r_presc <= w_tick ? '0 : r_presc + 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.oPulse   = r_pulse;
  assign bus.oChanged = r_chg;
  assign bus.oActive  = (r_state == ST_RUN);
  assign bus.oSelErr  = r_selerr;

endmodule
